// File: rtl/i2s_pkg.sv
// Shared I2S widths and sample type, used by receiver and transmitter.
// Plain package, no configuration macros.
package i2s_pkg;
  localparam int I2S_DATA_W = 16;
  localparam int I2S_SLOT_W = 16;
  localparam int CNT_W = 6;
  typedef logic [I2S_DATA_W-1:0] sample_t;
endpackage

// File: rtl/i2s_receiver_if.sv
// I2S serial bus plus recovered stereo sample outputs.
// master drives the serial lines, slave is the receiver.
interface i2s_receiver_if #(
  parameter int DATA_W = 16
);
  logic              serial_clk;
  logic              word_select;
  logic              sound_bit_in;
  logic [DATA_W-1:0] left_sample;
  logic [DATA_W-1:0] right_sample;
  logic              sample_valid;
  logic              locked;
  logic              frame_err;

  modport master (
    output serial_clk, word_select, sound_bit_in,
    input  left_sample, right_sample,
    input  sample_valid, locked, frame_err
  );

  modport slave (
    input  serial_clk, word_select, sound_bit_in,
    output left_sample, right_sample,
    output sample_valid, locked, frame_err
  );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous input bit.
// Cleared to 0 by the asynchronous active-low reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta_q;
  logic sync_q;

  // Two-stage capture into the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/i2s_receiver.sv
// I2S stereo receiver oversampling serial_clk on input_clk.
// Define I2S_RX_FRAME_CHECK_EN to build the sticky slot-length checker.
module i2s_receiver
  import i2s_pkg::*;
#(
  parameter int DATA_W = I2S_DATA_W,
  parameter int SLOT_W = I2S_SLOT_W
) (
  input logic     input_clk,
  input logic     reset,
  i2s_receiver_if.slave bus
);
  localparam int CAP_W = (DATA_W < SLOT_W) ? DATA_W : SLOT_W;
  localparam logic [CNT_W-1:0] DATA_N = CNT_W'(CAP_W);

  logic sck_s, ws_s, sd_s;

  sync_2ff u_sync_sck (
    .clk(input_clk), .rst_n(reset),
    .d(bus.serial_clk), .q(sck_s)
  );
  sync_2ff u_sync_ws (
    .clk(input_clk), .rst_n(reset),
    .d(bus.word_select), .q(ws_s)
  );
  sync_2ff u_sync_sd (
    .clk(input_clk), .rst_n(reset),
    .d(bus.sound_bit_in), .q(sd_s)
  );

  logic              sck_prev_q, sck_prev_d;
  logic              ws_prev_q, ws_prev_d;
  logic              ws_seen_q, ws_seen_d;
  logic              locked_q, locked_d;
  logic              hold_ok_q, hold_ok_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] left_q, left_d;
  logic [DATA_W-1:0] right_q, right_d;

  logic              rise, trans, take;
  logic [CNT_W-1:0]  cnt_inc;
  logic [DATA_W-1:0] shifted, nxt_sh, word;

  assign rise    = sck_s & ~sck_prev_q;
  assign trans   = rise & ws_seen_q & (ws_s != ws_prev_q);
  assign take    = locked_q & (cnt_q < DATA_N);
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign shifted = (shreg_q << 1) | DATA_W'(sd_s);
  assign nxt_sh  = take ? shifted : shreg_q;
  assign word    = (cnt_inc < DATA_N)
                 ? nxt_sh << (DATA_N - cnt_inc)
                 : nxt_sh;

  // Slot assembly and stereo pairing, advanced on serial_clk rises
  always_comb begin
    sck_prev_d = sck_s;
    ws_prev_d  = ws_prev_q;
    ws_seen_d  = ws_seen_q;
    locked_d   = locked_q;
    hold_ok_d  = hold_ok_q;
    valid_d    = 1'b0;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    hold_d     = hold_q;
    left_d     = left_q;
    right_d    = right_q;
    if (rise) begin
      ws_prev_d = ws_s;
      ws_seen_d = 1'b1;
      if (locked_q) begin
        cnt_d   = cnt_inc;
        shreg_d = nxt_sh;
      end
      if (trans) begin
        locked_d = 1'b1;
        cnt_d    = '0;
        shreg_d  = '0;
        if (locked_q && ws_s) begin
          hold_d    = word;
          hold_ok_d = 1'b1;
        end else if (locked_q && hold_ok_q) begin
          left_d  = hold_q;
          right_d = word;
          valid_d = 1'b1;
        end
      end
    end
  end

  // Receiver state registers
  always_ff @(posedge input_clk or negedge reset) begin
    if (!reset) begin
      sck_prev_q <= 1'b0;
      ws_prev_q  <= 1'b0;
      ws_seen_q  <= 1'b0;
      locked_q   <= 1'b0;
      hold_ok_q  <= 1'b0;
      valid_q    <= 1'b0;
      cnt_q      <= '0;
      shreg_q    <= '0;
      hold_q     <= '0;
      left_q     <= '0;
      right_q    <= '0;
    end else begin
      sck_prev_q <= sck_prev_d;
      ws_prev_q  <= ws_prev_d;
      ws_seen_q  <= ws_seen_d;
      locked_q   <= locked_d;
      hold_ok_q  <= hold_ok_d;
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      hold_q     <= hold_d;
      left_q     <= left_d;
      right_q    <= right_d;
    end
  end

  assign bus.left_sample  = left_q;
  assign bus.right_sample = right_q;
  assign bus.sample_valid = valid_q;
  assign bus.locked       = locked_q;

`ifdef I2S_RX_FRAME_CHECK_EN
  logic       ferr_q, ferr_d;
  logic [6:0] slot_len;

  assign slot_len = {1'b0, cnt_q} + 7'd1;

  // Sticky flag for any post-lock slot of the wrong length
  always_comb begin
    ferr_d = ferr_q;
    if (trans && locked_q && (slot_len != 7'(SLOT_W)))
      ferr_d = 1'b1;
  end

  // Frame error register, cleared only by reset
  always_ff @(posedge input_clk or negedge reset) begin
    if (!reset) ferr_q <= 1'b0;
    else        ferr_q <= ferr_d;
  end

  assign bus.frame_err = ferr_q;
`else
  assign bus.frame_err = 1'b0;
`endif
endmodule

// File: tb/tb_i2s_receiver.sv
// Directed bench for i2s_receiver: lock, pairing, short/long slots,
// stopped bit clock and mid-frame reset.
module tb_i2s_receiver;
  import i2s_pkg::*;

`ifdef I2S_RX_FRAME_CHECK_EN
  localparam logic FERR_EXP = 1'b1;
`else
  localparam logic FERR_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_vld = 0;
  int   v0;

  i2s_receiver_if #(.DATA_W(16)) bus ();

  i2s_receiver #(
    .DATA_W(16),
    .SLOT_W(16)
  ) dut (
    .input_clk(clk),
    .reset    (rst_n),
    .bus      (bus)
  );

  always #40 clk = ~clk;

  always @(negedge clk)
    if (bus.sample_valid === 1'b1) n_vld++;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bit_out(logic ws, logic sd);
    bus.word_select  = ws;
    bus.sound_bit_in = sd;
    #160 bus.serial_clk = 1'b1;
    #160 bus.serial_clk = 1'b0;
  endtask

  task automatic slot(logic ch, logic [31:0] w, int n);
    for (int i = n - 1; i >= 0; i--)
      bit_out((i == 0) ? ~ch : ch, w[i]);
  endtask

  task automatic frame(logic [31:0] l, logic [31:0] r);
    slot(1'b0, l, 16);
    slot(1'b1, r, 16);
  endtask

  task automatic settle();
    #640;
  endtask

  task automatic do_reset();
    rst_n            = 1'b0;
    bus.serial_clk   = 1'b0;
    bus.word_select  = 1'b0;
    bus.sound_bit_in = 1'b0;
    #400;
    rst_n = 1'b1;
    #160;
  endtask

  initial begin
    sample_t l_exp;
    bus.serial_clk   = 1'b0;
    bus.word_select  = 1'b0;
    bus.sound_bit_in = 1'b0;
    #7;
    do_reset();
    chk("rst_left",  32'(bus.left_sample), 0);
    chk("rst_right", 32'(bus.right_sample), 0);
    chk("rst_valid", 32'(bus.sample_valid), 0);
    chk("rst_locked", 32'(bus.locked), 0);
    chk("rst_ferr",  32'(bus.frame_err), 0);

    v0 = n_vld;
    frame(32'hA5C3, 32'h1234);
    settle();
    chk("lock_first", 32'(bus.locked), 1);
    chk("no_vld_first", 32'(n_vld - v0), 0);
    frame(32'hA5C3, 32'h1234);
    settle();
    chk("vld_once", 32'(n_vld - v0), 1);
    chk("basic_left", 32'(bus.left_sample), 32'hA5C3);
    chk("basic_right", 32'(bus.right_sample), 32'h1234);
    chk("basic_ferr", 32'(bus.frame_err), 0);

    do_reset();
    v0 = n_vld;
    slot(1'b0, 32'h15, 5);
    settle();
    chk("mid_locked", 32'(bus.locked), 1);
    chk("mid_no_vld0", 32'(n_vld - v0), 0);
    slot(1'b1, 32'h7F01, 16);
    settle();
    chk("mid_no_vld1", 32'(n_vld - v0), 0);
    frame(32'h8000, 32'h7FFF);
    settle();
    chk("mid_vld", 32'(n_vld - v0), 1);
    chk("mid_left", 32'(bus.left_sample), 32'h8000);
    chk("mid_right", 32'(bus.right_sample), 32'h7FFF);
    chk("mid_ferr", 32'(bus.frame_err), 0);

    slot(1'b0, {15'h0, 16'h5A69, 1'b1}, 17);
    slot(1'b1, 32'hBEEF, 16);
    settle();
    chk("long_vld", 32'(n_vld - v0), 2);
    chk("long_left", 32'(bus.left_sample), 32'h5A69);
    chk("long_right", 32'(bus.right_sample), 32'hBEEF);
    chk("long_ferr", 32'(bus.frame_err), 32'(FERR_EXP));

    do_reset();
    v0 = n_vld;
    frame(32'h0, 32'h0);
    slot(1'b0, 32'hFFF, 12);
    slot(1'b1, 32'h8001, 16);
    settle();
    l_exp = 16'hFFF0;
    chk("short_vld", 32'(n_vld - v0), 1);
    chk("short_left", 32'(bus.left_sample), 32'(l_exp));
    chk("short_right", 32'(bus.right_sample), 32'h8001);

    repeat (10) begin
      bus.word_select  = ~bus.word_select;
      bus.sound_bit_in = ~bus.sound_bit_in;
      #8000;
    end
    bus.word_select  = 1'b0;
    bus.sound_bit_in = 1'b0;
    chk("stop_vld", 32'(n_vld - v0), 1);
    chk("stop_left", 32'(bus.left_sample), 32'hFFF0);
    chk("stop_right", 32'(bus.right_sample), 32'h8001);
    chk("stop_locked", 32'(bus.locked), 1);

    fork
      frame(32'hC001, 32'h0FF0);
      begin
        #1600;
        rst_n = 1'b0;
        #1;
        chk("arst_left", 32'(bus.left_sample), 0);
        chk("arst_right", 32'(bus.right_sample), 0);
        chk("arst_valid", 32'(bus.sample_valid), 0);
        chk("arst_locked", 32'(bus.locked), 0);
        chk("arst_ferr", 32'(bus.frame_err), 0);
        #79;
        rst_n = 1'b1;
      end
    join
    v0 = n_vld;
    frame(32'h1357, 32'hFDB9);
    settle();
    chk("relock_vld", 32'(n_vld - v0), 1);
    chk("relock_left", 32'(bus.left_sample), 32'h1357);
    chk("relock_right", 32'(bus.right_sample), 32'hFDB9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
